seg_scan_decoder: RTL

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan decoder: active-low segment patterns,
// decode codes, blank-slot enable value and the settle/lock state type.
package seg_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;

   localparam logic [3:0] CODE_INVALID = 4'hF;
   localparam logic [7:0] ENABLE_BLANK = 8'hFF;

   typedef enum logic {
      SETTLING = 1'b0,
      LOCKED   = 1'b1
   } scan_state_t;

   // Number of asserted (low) digit selects in an active-low enable vector.
   function automatic logic [3:0] count_low(input logic [7:0] sel);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, ~sel[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low seven-segment pattern to digit code lookup; zero latency.
// Unknown patterns return CODE_INVALID with valid low.
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] code,
   output logic       valid
);

   always_comb begin
      code  = CODE_INVALID;
      valid = 1'b1;
      case (seg)
         SEG_0:   code = 4'd0;
         SEG_1:   code = 4'd1;
         SEG_2:   code = 4'd2;
         SEG_3:   code = 4'd3;
         SEG_4:   code = 4'd4;
         SEG_5:   code = 4'd5;
         SEG_6:   code = 4'd6;
         SEG_7:   code = 4'd7;
         SEG_8:   code = 4'd8;
         SEG_9:   code = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Captures a multiplexed 8-digit seven-segment scan into 4-bit digit codes; a slot is accepted
// after 2 sync + STABLE_CYCLES settle + 1 register cycles; no backpressure, frame_valid is a pulse.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 16
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  enable,
   input  logic [6:0]  iData,
   output logic [31:0] digit_code,
   output logic        frame_valid,
   output logic [7:0]  frame_cnt,
   output logic        seg_err,
   output logic        sel_err
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   logic [7:0]  en_meta, en_sync;
   logic [6:0]  dat_meta, dat_sync;
   logic [14:0] sample, sample_q;
   logic        sample_chg;
   logic [7:0]  stable_cnt;
   scan_state_t state_q, state_d;
   logic        accept;

   logic [3:0]  low_cnt;
   logic [2:0]  slot_idx;
   logic [3:0]  dec_code;
   logic        dec_valid;
   logic        wr_digit, bad_sel, frame_done;
   logic [7:0]  seen_mask, seen_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_meta  <= '1;
         en_sync  <= '1;
         dat_meta <= '1;
         dat_sync <= '1;
         sample_q <= '1;
      end else begin
         en_meta  <= enable;
         en_sync  <= en_meta;
         dat_meta <= iData;
         dat_sync <= dat_meta;
         sample_q <= sample;
      end
   end

   assign sample     = {en_sync, dat_sync};
   assign sample_chg = (sample != sample_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SETTLING;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLING: if (!sample_chg && stable_cnt == CNT_LAST) state_d = LOCKED;
         LOCKED:   if (sample_chg) state_d = SETTLING;
         default:  state_d = SETTLING;
      endcase
   end

   // A change in the would-be accept cycle wins: no accept, counter restarts.
   always_comb begin
      accept = 1'b0;
      if (state_q == SETTLING && !sample_chg && stable_cnt == CNT_LAST) accept = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_cnt <= '0;
      end else if (sample_chg) begin
         stable_cnt <= '0;
      end else if (state_q == SETTLING) begin
         stable_cnt <= stable_cnt + 8'd1;
      end
   end

   seg7_to_bcd u_seg7_to_bcd (
      .seg   (dat_sync),
      .code  (dec_code),
      .valid (dec_valid)
   );

   assign low_cnt = count_low(en_sync);

   always_comb begin
      slot_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (!en_sync[i]) slot_idx = 3'(i);
      end
   end

   assign wr_digit   = accept && (low_cnt == 4'd1);
   assign bad_sel    = accept && (low_cnt > 4'd1);
   assign frame_done = (seen_mask == ENABLE_BLANK);

   // Completed mask clears in the pulse cycle; a write landing then starts the next frame.
   always_comb begin
      seen_nxt = frame_done ? 8'h00 : seen_mask;
      if (wr_digit) seen_nxt[slot_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         digit_code  <= '1;
         seen_mask   <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         seg_err     <= 1'b0;
         sel_err     <= 1'b0;
      end else begin
         seen_mask   <= seen_nxt;
         frame_valid <= frame_done;
         seg_err     <= wr_digit && !dec_valid;
         sel_err     <= bad_sel;
         if (frame_done) frame_cnt <= frame_cnt + 8'd1;
         if (wr_digit) digit_code[{slot_idx, 2'b00} +: 4] <= dec_code;
      end
   end

endmodule
